rect_plotter: RTL and testbench
===============================

Name: rect_plotter

Overview:
- Parametrised successor to the fixed 4x4 block drawer.
- Plots a rectangle of run-time width and height at a given origin, one pixel per clock, in raster order (x fastest).
- Supports fill, outline and erase modes, screen-edge clipping, and a per-pixel colour output, with a busy/done handshake.
- Sits between game/control logic and the VGA adapter's x/y/colour/plot write port.

Parameters:
- COORD_W, 8, width of x/y coordinates.
- SIZE_W, 4, width of the w_in/h_in size fields; maximum rectangle is (2^SIZE_W - 1) square.
- COLOUR_W, 3, width of the colour bus.
- SCREEN_W, 160, number of visible columns; x >= SCREEN_W is clipped.
- SCREEN_H, 120, number of visible rows; y >= SCREEN_H is clipped.
- BG_COLOUR, 0, colour driven in erase mode.

Ports:
- clock, input, 1, system clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; a rising edge is accepted only in IDLE.
- x_in, input, COORD_W, origin column (top-left).
- y_in, input, COORD_W, origin row.
- w_in, input, SIZE_W, width in pixels.
- h_in, input, SIZE_W, height in pixels.
- colour_in, input, COLOUR_W, draw colour.
- mode, input, 2, 00 fill, 01 outline, 10 erase, 11 treated as fill.
- x, output, COORD_W, pixel column.
- y, output, COORD_W, pixel row.
- colour, output, COLOUR_W, pixel colour.
- plot, output, 1, write strobe for the current x/y/colour.
- busy, output, 1, high while a rectangle is in progress.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; x, y, colour, plot, busy, done all 0.
  - Internal counters and latches cleared; start edge-detect register cleared.
  - Reset asserted mid-rectangle aborts the rectangle immediately; no done pulse is produced.
- Start detection: start_q registers start every cycle. The trigger is start & ~start_q. A trigger outside IDLE is ignored and is not queued.
- State IDLE: busy=0. On the trigger, latch x_in, y_in, w_in, h_in, colour_in and mode, then go to LOAD. Later input changes have no effect until the next start.
- State LOAD (1 cycle): busy=1.
  - If w=0 or h=0, go to DONE.
  - Otherwise clear dx=0, dy=0 and go to PLOT.
- State PLOT (exactly w*h cycles): busy=1. Each cycle registers, visible on the next edge:
  - x = x0+dx and y = y0+dy, computed COORD_W+1 wide and truncated to COORD_W on output.
  - colour = BG_COLOUR in erase mode, otherwise the latched colour.
  - plot=1 unless suppressed:
    - Clipping: the untruncated sum is >= SCREEN_W (x) or >= SCREEN_H (y).
    - Outline mode: the pixel is not on the border (dx not 0 and not w-1, and dy not 0 and not h-1).
    - Suppressed pixels still take their cycle, so latency is independent of mode and clipping.
  - Advance: if dx = w-1, then dx=0 and dy increments; else dx increments.
  - After the pixel with dx=w-1 and dy=h-1, go to DONE.
- State DONE (1 cycle): busy=0, done=1 (registered, visible the cycle after the final pixel's outputs). Next state is IDLE.
- plot is low in IDLE, LOAD and DONE. x, y and colour hold their last values when plot is low.
- Latency: trigger edge to first plot=1 is 2 cycles. Total busy duration is 1 + w*h cycles.
- A start that is held high across DONE does not retrigger; it must fall and rise again.
- Outline mode with w=1 or h=1: every pixel is a border pixel, so it behaves like fill.

Test Plan:
- Reset, then start edge with x_in=10, y_in=20, w=4, h=4, fill, colour=5:
  - 16 plot pulses on consecutive cycles, (10,20),(11,20)...(13,23), colour=5.
  - busy high for 17 cycles; done pulses once; then IDLE.
- Outline, w=5, h=4 at (0,0): 20 PLOT cycles; plot=1 on 14 border pixels only; interior (1..3,1..2) has plot=0; done after 21 busy cycles.
- Erase, BG_COLOUR=0, colour_in=7: every plotted pixel has colour=0.
- Clipping, x_in=158, y_in=118, w=4, h=4: only (158..159,118..119) plotted (4 pulses); 16 PLOT cycles total; no wrap to x=0.
- w=0, h=7: busy for 1 cycle, no plot, done pulse; a second start edge issued during PLOT of another job is ignored.
- reset_n low during PLOT (pixel 6 of 16): outputs immediately 0, no done; after release a new start draws from pixel 0.

Source files
------------

// File: rtl/rect_plotter.sv
// rect_plotter: plots a clipped fill/outline/erase rectangle one pixel per clock in raster order.
module rect_plotter #(
    parameter int COORD_W   = 8,
    parameter int SIZE_W    = 4,
    parameter int COLOUR_W  = 3,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BG_COLOUR = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [COORD_W-1:0]  x_in,
    input  logic [COORD_W-1:0]  y_in,
    input  logic [SIZE_W-1:0]   w_in,
    input  logic [SIZE_W-1:0]   h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic [1:0]          mode,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, LOAD, PLOT, DONE} state_t;
    state_t state, state_next;
    logic                start_q;
    logic [COORD_W-1:0]  x0, y0;
    logic [SIZE_W-1:0]   w, h, dx, dy, w_m1, h_m1;
    logic [COLOUR_W-1:0] c0;
    logic [1:0]          md;
    logic [COORD_W:0]    px, py;
    logic                trig, last, border, vis, row_end;
    assign trig    = start & ~start_q;
    assign w_m1    = w - SIZE_W'(1);
    assign h_m1    = h - SIZE_W'(1);
    assign row_end = dx == w_m1;
    assign last    = row_end && dy == h_m1;
    // Sums are one bit wider so off-screen pixels clip instead of wrapping to column/row 0.
    assign px      = {1'b0, x0} + (COORD_W+1)'(dx);
    assign py      = {1'b0, y0} + (COORD_W+1)'(dy);
    assign border  = dx == '0 || row_end || dy == '0 || dy == h_m1;
    assign vis     = px < (COORD_W+1)'(SCREEN_W) && py < (COORD_W+1)'(SCREEN_H) && (md != 2'b01 || border);
    assign busy    = state == LOAD || state == PLOT;
    always_comb begin
        state_next = (state == IDLE) ? (trig ? LOAD : IDLE) :
                     (state == LOAD) ? ((w == '0 || h == '0) ? DONE : PLOT) :
                     (state == PLOT) ? (last ? DONE : PLOT) : IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            x0      <= '0;
            y0      <= '0;
            w       <= '0;
            h       <= '0;
            c0      <= '0;
            md      <= '0;
            dx      <= '0;
            dy      <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= state == DONE;
            plot    <= state == PLOT && vis;
            if (state == IDLE && trig) begin
                x0 <= x_in;
                y0 <= y_in;
                w  <= w_in;
                h  <= h_in;
                c0 <= colour_in;
                md <= mode;
            end
            if (state == LOAD) begin
                dx <= '0;
                dy <= '0;
            end
            if (state == PLOT) begin
                dx <= row_end ? '0 : dx + SIZE_W'(1);
                dy <= row_end ? dy + SIZE_W'(1) : dy;
            end
            // Suppressed pixels leave the write port holding the last plotted pixel.
            if (state == PLOT && vis) begin
                x      <= px[COORD_W-1:0];
                y      <= py[COORD_W-1:0];
                colour <= md == 2'b10 ? COLOUR_W'(BG_COLOUR) : c0;
            end
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: per-cycle expectation arrays built from the rectangle rules, checked every cycle.
module tb_rect_plotter;
    logic       clock = 0, reset_n = 0, start = 0;
    logic [7:0] x_in = 0, y_in = 0, x, y;
    logic [3:0] w_in = 0, h_in = 0;
    logic [2:0] colour_in = 0, colour;
    logic [1:0] mode = 0;
    logic       plot, busy, done;

    rect_plotter dut (
        .clock(clock), .reset_n(reset_n), .start(start), .x_in(x_in), .y_in(y_in),
        .w_in(w_in), .h_in(h_in), .colour_in(colour_in), .mode(mode),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    bit e_plot[4096], e_busy[4096], e_done[4096];
    int e_x[4096], e_y[4096], e_c[4096];
    int checks = 0, errors = 0;
    int hx = 0, hy = 0, hc = 0;
    int n_plot = 0, n_busy = 0, n_done = 0, first_x = -1, first_y = -1;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", n, cyc, a, e);
        end
    endtask

    // Expected behaviour of one job whose trigger edge makes cyc == e.
    function automatic void sched(input int e, input int px, input int py, input int w,
                                  input int h, input int c, input int m);
        int n = w * h;
        for (int t = e; t <= e + n; t++) e_busy[t] = 1;
        e_done[e + 2 + n] = 1;
        for (int i = 0; i < n; i++) begin
            int dx = i % w;
            int dy = i / w;
            int xs = px + dx;
            int ys = py + dy;
            bit edge_px = dx == 0 || dx == w - 1 || dy == 0 || dy == h - 1;
            if (xs < 160 && ys < 120 && (m != 1 || edge_px)) begin
                e_plot[e + 2 + i] = 1;
                e_x[e + 2 + i] = xs % 256;
                e_y[e + 2 + i] = ys % 256;
                e_c[e + 2 + i] = (m == 2) ? 0 : c;
            end
        end
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (e_plot[cyc]) begin
                hx = e_x[cyc];
                hy = e_y[cyc];
                hc = e_c[cyc];
            end
            chk("busy", int'(busy), int'(e_busy[cyc]));
            chk("done", int'(done), int'(e_done[cyc]));
            chk("plot", int'(plot), int'(e_plot[cyc]));
            chk("x", int'(x), hx);
            chk("y", int'(y), hy);
            chk("colour", int'(colour), hc);
            n_plot += int'(plot);
            n_busy += int'(busy);
            n_done += int'(done);
            if (plot && first_x < 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
        end
    end

    task automatic begin_job(input int px, input int py, input int w, input int h,
                             input int c, input int m);
        @(negedge clock);
        x_in = 8'(px); y_in = 8'(py); w_in = 4'(w); h_in = 4'(h);
        colour_in = 3'(c); mode = 2'(m); start = 1;
        sched(cyc + 1, px, py, w, h, c, m);
        n_plot = 0; n_busy = 0; n_done = 0; first_x = -1; first_y = -1;
    endtask

    task automatic run(input int px, input int py, input int w, input int h, input int c,
                       input int m, input bit hold, input bit restart);
        begin_job(px, py, w, h, c, m);
        @(negedge clock);
        if (!hold) start = 0;
        x_in = 8'd99; y_in = 8'd99; w_in = 4'd9; colour_in = 3'd1; mode = 2'd0;
        if (restart) begin
            repeat (4) @(negedge clock);
            start = 1;
            @(negedge clock);
            start = 0;
        end
        repeat (w * h + 6) @(negedge clock);
        start = 0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_xy", int'({x, y}), 0);
        reset_n = 1;
        repeat (2) @(negedge clock);

        run(10, 20, 4, 4, 5, 0, 0, 1);
        chk("fill_n_plot", n_plot, 16);
        chk("fill_n_busy", n_busy, 17);
        chk("fill_n_done", n_done, 1);
        chk("fill_first_x", first_x, 10);
        chk("fill_first_y", first_y, 20);

        run(0, 0, 5, 4, 6, 1, 1, 0);
        chk("outline_n_plot", n_plot, 14);
        chk("outline_n_busy", n_busy, 21);
        chk("outline_n_done", n_done, 1);

        run(30, 40, 3, 2, 7, 2, 0, 0);
        chk("erase_n_plot", n_plot, 6);

        run(158, 118, 4, 4, 3, 0, 0, 0);
        chk("clip_n_plot", n_plot, 4);
        chk("clip_n_busy", n_busy, 17);
        chk("clip_last_x", int'(x), 159);

        run(50, 50, 0, 7, 1, 0, 0, 0);
        chk("zero_n_plot", n_plot, 0);
        chk("zero_n_busy", n_busy, 1);
        chk("zero_n_done", n_done, 1);

        run(5, 5, 2, 3, 4, 3, 0, 0);
        chk("mode3_n_plot", n_plot, 6);
        run(7, 9, 1, 3, 2, 1, 0, 0);
        chk("outline_thin_n_plot", n_plot, 3);

        begin_job(60, 60, 4, 4, 6, 0);
        @(negedge clock);
        start = 0;
        repeat (8) @(negedge clock);
        chk("abort_px6_x", int'(x), 62);
        chk("abort_px6_y", int'(y), 61);
        #2 reset_n = 0;
        for (int t = cyc + 1; t < 4096; t++) begin
            e_plot[t] = 0; e_busy[t] = 0; e_done[t] = 0;
        end
        hx = 0; hy = 0; hc = 0;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_x", int'(x), 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        repeat (3) @(negedge clock);
        run(60, 60, 4, 4, 6, 0, 0, 0);
        chk("after_abort_first_x", first_x, 60);
        chk("after_abort_first_y", first_y, 60);
        chk("after_abort_n_plot", n_plot, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
